// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC result port slice.
// Holds the result-FSM state encoding and the default result/angle widths
// used by the interface, the FIFO wrapper and the top module.
package cordic_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DATA_W_DEF  = 16;
    localparam int ANGLE_W_DEF = 16;

endpackage

// File: rtl/cordic_result_port_if.sv
// Result handshake bundle between the CORDIC result port and its consumer.
//   res_valid  head entry valid (producer -> consumer)
//   res_ready  consumer accepts head on res_valid && res_ready
//   res_angle  angle tag of head entry
//   res_cos    cos result of head entry
//   res_sin    sin result of head entry
// master: the result port; slave: the consumer (bus slave, DAC path).
interface cordic_result_port_if #(
    parameter int DATA_W  = cordic_pkg::DATA_W_DEF,
    parameter int ANGLE_W = cordic_pkg::ANGLE_W_DEF
);

    logic               res_valid;
    logic               res_ready;
    logic [ANGLE_W-1:0] res_angle;
    logic [DATA_W-1:0]  res_cos;
    logic [DATA_W-1:0]  res_sin;

    modport master (
        output res_valid,
        input  res_ready,
        output res_angle,
        output res_cos,
        output res_sin
    );

    modport slave (
        input  res_valid,
        output res_ready,
        input  res_angle,
        input  res_cos,
        input  res_sin
    );

endinterface

// File: rtl/cordic_res_fifo2.sv
// Two-entry FIFO holding packed {angle, cos, sin} results.
// Ports:
//   clk, rst   clock, async active-high reset
//   push, din  write request and data
//   pop        read request (head leaves on this edge)
//   dout       head entry (storage read, no extra latency)
//   full/empty occupancy flags, count = 0..2
// A push while full is accepted only if a pop happens on the same edge;
// otherwise it is discarded and the caller accounts for the drop.
module cordic_res_fifo2 #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (cnt != 2'd0);
    // When full, the write slot equals the head slot; a simultaneous pop
    // frees it on the same edge, so the new entry lands at the tail.
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign count = cnt;

endmodule

// File: rtl/cordic_result_port.sv
// Downstream end of the CORDIC controller/datapath pair. Tracks each launched
// computation, captures {angle, cos, sin} on datapath done, and buffers up to
// two results for the consumer. Flags dropped results, aborts and timeouts.
// Ports:
//   clk, rst           clock, async active-high reset
//   cordic_rst         controller datapath reset; 1->0 launches a computation
//   done               datapath done (level)
//   angle              angle presented to the controller, tagged at launch
//   cos_in, sin_in     datapath results, valid while done=1
//   res                result handshake (master side)
//   busy               computation in flight
//   overrun, drop_cnt  sticky drop flag and saturating drop count
//   abort_p, timeout_p single-cycle event pulses
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a cordic_rst falling edge; done is ignored
// ST_RUN  | computation in flight; ends on done, cordic_rst or timeout
module cordic_result_port
    import cordic_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ANGLE_W = ANGLE_W_DEF,
    parameter int TIMEOUT = 24,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cordic_rst,
    input  logic                 done,
    input  logic [ANGLE_W-1:0]   angle,
    input  logic [DATA_W-1:0]    cos_in,
    input  logic [DATA_W-1:0]    sin_in,
    cordic_result_port_if.master res,
    output logic                 busy,
    output logic                 overrun,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 abort_p,
    output logic                 timeout_p
);

    localparam int                FIFO_W    = ANGLE_W + 2 * DATA_W;
    localparam int                TICK_W    = $clog2(TIMEOUT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic               cordic_rst_q;
    logic               start;
    logic [TICK_W-1:0]  tick;
    logic [ANGLE_W-1:0] tag;
    logic               push;
    logic               pop;
    logic               abort_nxt;
    logic               timeout_nxt;
    logic               drop;
    logic [FIFO_W-1:0]  fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [1:0]         fifo_count_unused;

    assign start = cordic_rst_q && !cordic_rst;

    always_comb begin
        state_nxt   = state;
        push        = 1'b0;
        abort_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // done wins over a same-cycle abort or timeout
                if (done) begin
                    push      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cordic_rst) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tick == TICK_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cordic_rst_q <= 1'b0;
            tick         <= '0;
            tag          <= '0;
            abort_p      <= 1'b0;
            timeout_p    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cordic_rst_q <= cordic_rst;
            abort_p      <= abort_nxt;
            timeout_p    <= timeout_nxt;
            if ((state == ST_IDLE) && start) begin
                tag  <= angle;
                tick <= '0;
            end else if ((state == ST_RUN) && (state_nxt == ST_RUN)) begin
                tick <= tick + 1'b1;
            end
        end
    end

    assign busy = (state == ST_RUN);

    assign pop  = res.res_ready && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    cordic_res_fifo2 #(
        .W(FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({tag, cos_in, sin_in}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    assign res.res_valid = !fifo_empty;
    assign res.res_angle = fifo_dout[FIFO_W-1 -: ANGLE_W];
    assign res.res_cos   = fifo_dout[2*DATA_W-1 -: DATA_W];
    assign res.res_sin   = fifo_dout[DATA_W-1:0];

endmodule

// File: tb/tb_cordic_result_port.sv
module tb_cordic_result_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        cordic_rst;
    logic        done;
    logic [15:0] angle;
    logic [15:0] cos_in;
    logic [15:0] sin_in;
    logic        busy;
    logic        overrun;
    logic [7:0]  drop_cnt;
    logic        abort_p;
    logic        timeout_p;

    int checks   = 0;
    int failures = 0;

    cordic_result_port_if #(.DATA_W(16), .ANGLE_W(16)) rif ();

    cordic_result_port #(
        .DATA_W(16), .ANGLE_W(16), .TIMEOUT(24), .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cordic_rst (cordic_rst),
        .done       (done),
        .angle      (angle),
        .cos_in     (cos_in),
        .sin_in     (sin_in),
        .res        (rif.master),
        .busy       (busy),
        .overrun    (overrun),
        .drop_cnt   (drop_cnt),
        .abort_p    (abort_p),
        .timeout_p  (timeout_p)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] a);
        cordic_rst = 1'b1;
        step();
        cordic_rst = 1'b0;
        angle      = a;
        step();
    endtask

    task automatic finish_comp(input logic [15:0] c, input logic [15:0] s);
        done   = 1'b1;
        cos_in = c;
        sin_in = s;
        step();
        done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cordic_rst = 1'b0; done = 1'b0;
        angle = '0; cos_in = '0; sin_in = '0; rif.res_ready = 1'b0;
        step(); step();
        checks++;
        if ({rif.res_valid, busy, overrun, abort_p, timeout_p} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {rif.res_valid, busy, overrun, abort_p, timeout_p});
        end
        checks++;
        if ({rif.res_angle, rif.res_cos, rif.res_sin, drop_cnt} !== 56'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0",
                     {rif.res_angle, rif.res_cos, rif.res_sin, drop_cnt});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_result();
        launch(16'h2000);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL t1_busy_run got=%b exp=1", busy);
        end
        repeat (15) step();
        finish_comp(16'h4DBA, 16'h4DBA);
        checks++;
        if (rif.res_valid !== 1'b1) begin
            failures++; $display("FAIL t1_valid got=%b exp=1", rif.res_valid);
        end
        checks++;
        if ({rif.res_angle, rif.res_cos, rif.res_sin} !== 48'h2000_4DBA_4DBA) begin
            failures++;
            $display("FAIL t1_data got=%h exp=20004dba4dba",
                     {rif.res_angle, rif.res_cos, rif.res_sin});
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL t1_busy_idle got=%b exp=0", busy);
        end
        step();
        checks++;
        if ({rif.res_valid, rif.res_angle} !== {1'b1, 16'h2000}) begin
            failures++;
            $display("FAIL t1_hold got=%h exp=12000", {rif.res_valid, rif.res_angle});
        end
        rif.res_ready = 1'b1;
        step();
        rif.res_ready = 1'b0;
        checks++;
        if (rif.res_valid !== 1'b0) begin
            failures++; $display("FAIL t1_popped got=%b exp=0", rif.res_valid);
        end
    endtask

    task automatic test_done_held();
        int pops;
        logic [15:0] got_angle;
        pops = 0;
        got_angle = '0;
        launch(16'h1111);
        repeat (3) step();
        rif.res_ready = 1'b1;
        done = 1'b1; cos_in = 16'h1234; sin_in = 16'h5678;
        for (int i = 0; i < 10; i++) begin
            if (rif.res_valid) begin
                pops++;
                got_angle = rif.res_angle;
            end
            step();
        end
        done = 1'b0;
        rif.res_ready = 1'b0;
        checks++;
        if (pops !== 1) begin
            failures++; $display("FAIL t2_pop_count got=%0d exp=1", pops);
        end
        checks++;
        if (got_angle !== 16'h1111) begin
            failures++; $display("FAIL t2_angle got=%h exp=1111", got_angle);
        end
        checks++;
        if ({rif.res_valid, busy} !== 2'b00) begin
            failures++; $display("FAIL t2_idle got=%b exp=00", {rif.res_valid, busy});
        end
    endtask

    task automatic test_overrun();
        logic [15:0] a3 [3];
        logic [15:0] c3 [3];
        a3 = '{16'h0100, 16'h0200, 16'h0300};
        c3 = '{16'hA001, 16'hA002, 16'hA003};
        rif.res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            launch(a3[k]);
            repeat (2) step();
            finish_comp(c3[k], ~c3[k]);
            if (k == 1) begin
                checks++;
                if (overrun !== 1'b0) begin
                    failures++; $display("FAIL t3_no_early_overrun got=%b exp=0", overrun);
                end
            end
        end
        checks++;
        if ({overrun, drop_cnt} !== {1'b1, 8'd1}) begin
            failures++; $display("FAIL t3_drop got=%h exp=101", {overrun, drop_cnt});
        end
        checks++;
        if ({rif.res_valid, rif.res_angle, rif.res_cos} !== {1'b1, 16'h0100, 16'hA001}) begin
            failures++;
            $display("FAIL t3_head0 got=%h exp=10100a001",
                     {rif.res_valid, rif.res_angle, rif.res_cos});
        end
        rif.res_ready = 1'b1;
        step();
        checks++;
        if ({rif.res_valid, rif.res_angle, rif.res_sin} !== {1'b1, 16'h0200, 16'h5FFD}) begin
            failures++;
            $display("FAIL t3_head1 got=%h exp=102005ffd",
                     {rif.res_valid, rif.res_angle, rif.res_sin});
        end
        step();
        rif.res_ready = 1'b0;
        checks++;
        if (rif.res_valid !== 1'b0) begin
            failures++; $display("FAIL t3_empty got=%b exp=0", rif.res_valid);
        end
    endtask

    task automatic test_push_pop_full();
        rif.res_ready = 1'b0;
        launch(16'h0A00); step(); finish_comp(16'h000A, 16'h00A0);
        launch(16'h0B00); step(); finish_comp(16'h000B, 16'h00B0);
        launch(16'h0C00); step();
        done = 1'b1; cos_in = 16'h000C; sin_in = 16'h00C0;
        rif.res_ready = 1'b1;
        step();
        done = 1'b0;
        rif.res_ready = 1'b0;
        checks++;
        if ({overrun, drop_cnt} !== {1'b1, 8'd1}) begin
            failures++; $display("FAIL t4_no_drop got=%h exp=101", {overrun, drop_cnt});
        end
        checks++;
        if ({rif.res_valid, rif.res_angle} !== {1'b1, 16'h0B00}) begin
            failures++; $display("FAIL t4_head got=%h exp=10b00", {rif.res_valid, rif.res_angle});
        end
        rif.res_ready = 1'b1;
        step();
        checks++;
        if ({rif.res_valid, rif.res_angle, rif.res_cos, rif.res_sin} !==
            {1'b1, 16'h0C00, 16'h000C, 16'h00C0}) begin
            failures++;
            $display("FAIL t4_tail got=%h exp=10c00000c00c0",
                     {rif.res_valid, rif.res_angle, rif.res_cos, rif.res_sin});
        end
        step();
        rif.res_ready = 1'b0;
        checks++;
        if (rif.res_valid !== 1'b0) begin
            failures++; $display("FAIL t4_empty got=%b exp=0", rif.res_valid);
        end
    endtask

    task automatic test_abort_timeout();
        launch(16'h0D00);
        repeat (4) step();
        cordic_rst = 1'b1;
        checks++;
        if ({busy, abort_p} !== 2'b10) begin
            failures++; $display("FAIL t5_pre_abort got=%b exp=10", {busy, abort_p});
        end
        step();
        checks++;
        if ({abort_p, busy, rif.res_valid} !== 3'b100) begin
            failures++;
            $display("FAIL t5_abort got=%b exp=100", {abort_p, busy, rif.res_valid});
        end
        step();
        checks++;
        if (abort_p !== 1'b0) begin
            failures++; $display("FAIL t5_abort_pulse got=%b exp=0", abort_p);
        end
        launch(16'h0E00);
        repeat (23) step();
        checks++;
        if ({busy, timeout_p} !== 2'b10) begin
            failures++; $display("FAIL t5_pre_timeout got=%b exp=10", {busy, timeout_p});
        end
        step();
        checks++;
        if ({timeout_p, busy, rif.res_valid} !== 3'b100) begin
            failures++;
            $display("FAIL t5_timeout got=%b exp=100", {timeout_p, busy, rif.res_valid});
        end
        step();
        checks++;
        if (timeout_p !== 1'b0) begin
            failures++; $display("FAIL t5_timeout_pulse got=%b exp=0", timeout_p);
        end
    endtask

    task automatic test_async_reset();
        launch(16'h0F00);
        step();
        finish_comp(16'h0001, 16'h0002);
        launch(16'h1000);
        step();
        checks++;
        if ({busy, rif.res_valid} !== 2'b11) begin
            failures++; $display("FAIL t6_pre got=%b exp=11", {busy, rif.res_valid});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rif.res_valid, busy, overrun, abort_p, timeout_p} !== 5'b0) begin
            failures++;
            $display("FAIL t6_flags got=%b exp=00000",
                     {rif.res_valid, busy, overrun, abort_p, timeout_p});
        end
        checks++;
        if ({rif.res_angle, rif.res_cos, rif.res_sin, drop_cnt} !== 56'h0) begin
            failures++;
            $display("FAIL t6_data got=%h exp=0",
                     {rif.res_angle, rif.res_cos, rif.res_sin, drop_cnt});
        end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_result();
        test_done_held();
        test_overrun();
        test_push_pop_full();
        test_abort_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
